// File: rtl/key_debounce_mc.sv
// Multi-channel key conditioner: synchronizer, stable-sample filter,
// press/release pulses, long-press event and auto-repeat per channel.
module key_debounce_mc #(
    parameter int N            = 4,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int LONG_CYC     = 50000000,
    parameter int REPEAT_CYC   = 10000000,
    parameter int ACTIVE_LOW   = 1,
    parameter int REPEAT_EN    = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] key,
    output logic [N-1:0] key_state,
    output logic [N-1:0] key_press,
    output logic [N-1:0] key_release,
    output logic [N-1:0] key_long,
    output logic [N-1:0] key_repeat
);

    localparam int DW   = $clog2(DEBOUNCE_CYC);
    localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
    localparam int HW   = $clog2(HMAX);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYC - 1);

    localparam logic [N-1:0] INACT = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_LONG = 2'd2;

    logic [N-1:0] s1;
    logic [N-1:0] s2;
    logic [N-1:0] lvl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= INACT;
            s2 <= INACT;
        end else begin
            s1 <= key;
            s2 <= s1;
        end
    end

    // Normalise so that 1 always means "pressed" downstream.
    assign lvl = (ACTIVE_LOW != 0) ? ~s2 : s2;

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [DW-1:0] db_cnt;
        logic          st_q;
        logic          press_q;
        logic          rel_q;
        logic          db_hit;
        logic          acc_press;
        logic          acc_rel;
        logic [1:0]    hstate;
        logic [HW-1:0] hcnt;
        logic          long_q;
        logic          rep_q;

        assign db_hit    = (lvl[i] != st_q) && (db_cnt == DB_LAST);
        assign acc_press = db_hit && lvl[i];
        assign acc_rel   = db_hit && !lvl[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db_cnt  <= '0;
                st_q    <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= acc_press;
                rel_q   <= acc_rel;
                if (lvl[i] == st_q) begin
                    db_cnt <= '0;
                end else if (db_hit) begin
                    db_cnt <= '0;
                    st_q   <= lvl[i];
                end else begin
                    db_cnt <= db_cnt + DW'(1);
                end
            end
        end

        // An accepted release always takes priority over hold thresholds.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hstate <= ST_IDLE;
                hcnt   <= '0;
                long_q <= 1'b0;
                rep_q  <= 1'b0;
            end else begin
                long_q <= 1'b0;
                rep_q  <= 1'b0;
                if (acc_rel) begin
                    hstate <= ST_IDLE;
                    hcnt   <= '0;
                end else begin
                    unique case (hstate)
                        ST_IDLE: begin
                            hcnt <= '0;
                            if (acc_press) begin
                                hstate <= ST_HELD;
                            end
                        end
                        ST_HELD: begin
                            if (hcnt == LONG_LAST) begin
                                long_q <= 1'b1;
                                hcnt   <= '0;
                                hstate <= ST_LONG;
                            end else begin
                                hcnt <= hcnt + HW'(1);
                            end
                        end
                        ST_LONG: begin
                            if (REPEAT_EN == 0) begin
                                hcnt <= '0;
                            end else if (hcnt == REP_LAST) begin
                                rep_q <= 1'b1;
                                hcnt  <= '0;
                            end else begin
                                hcnt <= hcnt + HW'(1);
                            end
                        end
                        default: begin
                            hstate <= ST_IDLE;
                            hcnt   <= '0;
                        end
                    endcase
                end
            end
        end

        assign key_state[i]   = st_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
        assign key_long[i]    = long_q;
        assign key_repeat[i]  = (REPEAT_EN != 0) ? rep_q : 1'b0;
    end

endmodule

// File: tb/tb_key_debounce_mc.sv
// Self-checking bench for key_debounce_mc: two DUTs (repeat on/off)
// driven in lock-step and compared each cycle to a behavioural model.
module tb_key_debounce_mc;

    localparam int N = 2;
    localparam int D = 4;
    localparam int L = 10;
    localparam int R = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] key = 2'b11;

    logic [N-1:0] ks, kp, kr, kl, kt;
    logic [N-1:0] ns, np, nr, nl, nt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_debounce_mc #(
        .N(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R),
        .ACTIVE_LOW(1), .REPEAT_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .key(key),
        .key_state(ks), .key_press(kp), .key_release(kr),
        .key_long(kl), .key_repeat(kt)
    );

    key_debounce_mc #(
        .N(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R),
        .ACTIVE_LOW(1), .REPEAT_EN(0)
    ) dut_nr (
        .clk(clk), .rst(rst), .key(key),
        .key_state(ns), .key_press(np), .key_release(nr),
        .key_long(nl), .key_repeat(nt)
    );

    // Model: pin history window, key toggles when the D samples seen
    // through the 2-stage delay all disagree; hold events from press age.
    bit h [N][D+2];
    logic [N-1:0] m_st = '0;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel = '0;
    logic [N-1:0] m_long = '0;
    logic [N-1:0] m_rep = '0;
    int age [N];
    bit held [N];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int c = 0; c < N; c++) begin
                    for (int k = 0; k < D + 2; k++) h[c][k] = 1'b0;
                    held[c] = 1'b0;
                    age[c] = 0;
                end
                m_st = '0; m_press = '0; m_rel = '0;
                m_long = '0; m_rep = '0;
            end else begin
                for (int c = 0; c < N; c++) begin
                    bit flip;
                    for (int k = D + 1; k > 0; k--) h[c][k] = h[c][k-1];
                    h[c][0] = ~key[c];
                    flip = 1'b1;
                    for (int k = 2; k < D + 2; k++)
                        if (h[c][k] == m_st[c]) flip = 1'b0;
                    m_press[c] = flip & ~m_st[c];
                    m_rel[c] = flip & m_st[c];
                    if (flip) m_st[c] = ~m_st[c];
                    m_long[c] = 1'b0;
                    m_rep[c] = 1'b0;
                    if (m_press[c]) begin
                        held[c] = 1'b1;
                        age[c] = 0;
                    end else if (m_rel[c]) begin
                        held[c] = 1'b0;
                    end else if (held[c]) begin
                        age[c]++;
                        if (age[c] == L) m_long[c] = 1'b1;
                        if (age[c] > L && (age[c] - L) % R == 0) m_rep[c] = 1'b1;
                    end
                end
            end
        end
    end

    wire [19:0] obs = {ks, kp, kr, kl, kt, ns, np, nr, nl, nt};
    wire [19:0] exp_v = {m_st, m_press, m_rel, m_long, m_rep,
                         m_st, m_press, m_rel, m_long, 2'b00};

    task automatic test_reset;
        rst = 1'b1;
        key = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 20'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %b exp 0", i, obs);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v || obs !== 20'd0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_clean_press;
        int press_at;
        press_at = -1;
        key = 2'b10;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL press cyc %0d got %b exp %b", i, obs, exp_v);
            end
            if (kp[0] && press_at < 0) press_at = i;
        end
        checks++;
        if (press_at !== 6) begin
            errors++;
            $display("FAIL press_latency got %0d exp 6", press_at);
        end
    endtask

    task automatic test_long_repeat;
        int reps;
        int rel_at;
        reps = 0;
        rel_at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL long_rep cyc %0d got %b exp %b", i, obs, exp_v);
            end
            if (kt[0]) reps++;
        end
        checks++;
        if (reps < 10) begin
            errors++;
            $display("FAIL repeat_count got %0d exp >=10", reps);
        end
        key = 2'b11;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL release cyc %0d got %b exp %b", i, obs, exp_v);
            end
            if (kr[0] && rel_at < 0) rel_at = i;
        end
        checks++;
        if (rel_at !== 6) begin
            errors++;
            $display("FAIL release_latency got %0d exp 6", rel_at);
        end
    endtask

    task automatic test_glitch;
        bit seen;
        seen = 1'b0;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 4; i++) begin
                key = (i < 3) ? 2'b10 : 2'b11;
                @(negedge clk);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL glitch g%0d c%0d got %b exp %b", g, i, obs, exp_v);
                end
                if (kp[0] || ks[0]) seen = 1'b1;
            end
        end
        for (int i = 0; i < 8; i++) @(negedge clk);
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL glitch_press got %b exp 0", seen);
        end
    endtask

    task automatic test_release_race;
        bit got_press;
        bit saw_long;
        bit saw_rel;
        got_press = 1'b0;
        saw_long = 1'b0;
        saw_rel = 1'b0;
        key = 2'b10;
        for (int i = 0; i < 20 && !got_press; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL race_press cyc %0d got %b exp %b", i, obs, exp_v);
            end
            got_press = kp[0];
        end
        checks++;
        if (!got_press) begin
            errors++;
            $display("FAIL race_press_timeout got 0 exp 1");
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL race_hold cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
        key = 2'b11;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL race_rel cyc %0d got %b exp %b", i, obs, exp_v);
            end
            if (kl[0]) saw_long = 1'b1;
            if (kr[0]) saw_rel = 1'b1;
        end
        checks++;
        if ({saw_rel, saw_long} !== 2'b10) begin
            errors++;
            $display("FAIL race_result got %b exp 10", {saw_rel, saw_long});
        end
    endtask

    task automatic test_both_nr;
        int longs;
        longs = 0;
        key = 2'b00;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v || np[0] !== np[1] || nl[0] !== nl[1] || nt !== 2'b00) begin
                errors++;
                $display("FAIL both cyc %0d got %b exp %b", i, obs, exp_v);
            end
            if (nl == 2'b11) longs++;
        end
        checks++;
        if (longs !== 1) begin
            errors++;
            $display("FAIL both_long got %0d exp 1", longs);
        end
        key = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL both_rel cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_hold;
        int press_at;
        bit saw_rel;
        press_at = -1;
        saw_rel = 1'b0;
        key = 2'b10;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL mid_hold cyc %0d got %b exp %b", i, obs, exp_v);
            end
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 20'd0) begin
            errors++;
            $display("FAIL async_reset got %b exp 0", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL post_reset cyc %0d got %b exp %b", i, obs, exp_v);
            end
            if (kp[0] && press_at < 0) press_at = i;
            if (kr[0]) saw_rel = 1'b1;
        end
        checks++;
        if (press_at !== 6 || saw_rel !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_press got %0d/%b exp 6/0", press_at, saw_rel);
        end
        key = 2'b11;
        for (int i = 0; i < 10; i++) @(negedge clk);
    endtask

    task automatic test_random;
        for (int s = 0; s < 60; s++) begin
            int len;
            key = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL random s%0d c%0d got %b exp %b", s, i, obs, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_long_repeat();
        test_glitch();
        test_release_race();
        test_both_nr();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce_mc.md
# key_debounce_mc

Multi-channel key conditioner that turns N raw, asynchronous push-button inputs into clean per-key pulses. It sits between the board key pins and the user-interface control logic, and replaces single-edge debouncing with several features per channel: a true consecutive-stable-sample filter, press and release pulses, a long-press event and a programmable auto-repeat. All channels are independent and share one clock.

## Interface
Parameters:
- N, 4, number of key channels
- DEBOUNCE_CYC, 1000000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be ≥2
- LONG_CYC, 50000000, cycles a key must stay accepted-pressed before key_long fires; must be ≥2
- REPEAT_CYC, 10000000, auto-repeat period after the long-press event; must be ≥2
- ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed
- REPEAT_EN, 1, 1 = generate key_repeat pulses; 0 = key_repeat tied to 0

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- key  input  N  raw key pins, asynchronous to clk
- key_state  output  N  debounced level per key, 1 = pressed
- key_press  output  N  one-cycle pulse per accepted press
- key_release  output  N  one-cycle pulse per accepted release
- key_long  output  N  one-cycle pulse when hold time reaches LONG_CYC
- key_repeat  output  N  one-cycle pulse every REPEAT_CYC after key_long, while the key is held

## Operation
- Synchronizer: there are two flip-flops per channel (s1, s2). Both reset to the inactive pin level, which is all-1 when ACTIVE_LOW=1. Normalised level: lvl = ACTIVE_LOW ? ~s2 : s2.
- Filter: each channel has a counter of width $clog2(DEBOUNCE_CYC).
  - If lvl == key_state, the counter clears.
  - Otherwise it increments.
  - When the counter equals DEBOUNCE_CYC-1 and lvl still differs, key_state <= lvl and the counter clears.
  - Any single matching cycle restarts the count. This gives glitch rejection.
- Edge pulses are registered and assert in the same cycle key_state changes:
  - key_press on a 0→1 change of key_state
  - key_release on a 1→0 change of key_state
- Hold FSM per channel has three states: IDLE, HELD, LONG. There is one hold counter per channel, sized for max(LONG_CYC, REPEAT_CYC).
  - IDLE → HELD on press, with the counter at 0.
  - In HELD the counter increments each cycle. When it reaches LONG_CYC-1, key_long pulses, the counter clears and the FSM moves to LONG.
  - In LONG with REPEAT_EN=1, the counter increments. When it reaches REPEAT_CYC-1, key_repeat pulses and the counter clears. The FSM stays in LONG.
  - In LONG with REPEAT_EN=0, the counter holds at 0.
  - Release from any state → IDLE, with the counter cleared.
- Boundary rules:
  - Release and a long or repeat threshold in the same cycle: release wins, and key_long / key_repeat stay 0.
  - key_press and key_long never coincide, because LONG_CYC ≥ 2.
  - Channels are fully independent; simultaneous activity on every channel is legal.
  - Counters never wrap. The filter and hold counters clear at their threshold.

## Timing
- Reset (asynchronous, any time, including mid-hold):
  - All outputs go to 0.
  - FSMs go to IDLE and all counters go to 0.
  - No release pulse is emitted for a key that was held at reset.
- After reset deassertion with keys idle, no pulses occur.
- Press latency: the pin changes and is stable before edge E0. Then key_state = 1 and key_press = 1 in the cycle after edge E(DEBOUNCE_CYC+1), i.e. DEBOUNCE_CYC+2 edges after sampling. Release latency is identical.
- key_long asserts LONG_CYC cycles after key_press. The k-th key_repeat asserts LONG_CYC + k·REPEAT_CYC cycles after key_press.
- All pulses are exactly one clk cycle wide.

## Test plan
Unless a line states otherwise, the bench uses N=2, DEBOUNCE_CYC=4, LONG_CYC=10, REPEAT_CYC=3, ACTIVE_LOW=1 and REPEAT_EN=1.
- Clean press: drive key[0] low and hold it → key_state[0] rises and key_press[0] pulses exactly 6 edges after the first sampling edge; key[1] outputs stay 0.
- Glitch rejection: key[0] low for 3 cycles then high for 1, repeated 5 times → no key_press, key_state stays 0.
- Long and repeat: hold key[0] low for 40 cycles after the press → key_long at press+10 and key_repeat at press+13, +16, +19, …; on release, key_release occurs 6 edges after the pin rises and no further repeats.
- Release racing the threshold: time the accepted release on the cycle the hold counter reaches 9 → key_release = 1, key_long = 0.
- Both channels pressed in the same cycle with REPEAT_EN=0 → identical, simultaneous press and long pulses on both channels, and key_repeat stays 0.
- Reset mid-hold: assert rst while key[0] is in LONG → all outputs go to 0 asynchronously. After rst is released with key[0] still low, a fresh key_press follows 6 edges later and no release pulse occurs.
